timing_gen: RTL and testbench
=============================

// Module: timing_gen
// PURPOSE
//  Beat/phase timing generator feeding the hardwired controller: produces one-hot
//  phase pulses t1/t2/t3 and beat levels w1/w2/w3. Beat sequencing obeys the controller's
//  short/long/stop requests. Runs from the qd start button; halts on stop.
//  Sits directly upstream of the controller, which consumes w1..w3 and t3.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  clocks qd must be stable after synchronisation before a level change is accepted
// PORTS
//  clk      in   1  system clock; all state updates on rising edge
//  clr      in   1  synchronous, active-high reset
//  qd       in   1  start pushbutton, asynchronous, active-high
//  short    in   1  from controller: current beat is the last; no W2
//  long     in   1  from controller: append W3 after W2
//  stop     in   1  from controller: halt after current beat
//  t1,t2,t3 out  1  one-hot phase within a beat; all 0 while halted
//  w1,w2,w3 out  1  one-hot beat level, held for all 3 phases; all 0 while halted
//  running  out  1  1 while sequencing beats
// BEHAVIOUR
//  - Reset (clr=1 at clk edge): running=0, t1..t3=0, w1..w3=0, debounce state cleared.
//    clr mid-beat aborts immediately; no partial beat completes.
//  - qd path: 2-flop synchroniser, then debouncer. The debounced level changes only after
//    DEBOUNCE_CYCLES consecutive equal samples. A 0->1 edge of the debounced level gives a
//    1-clock start pulse.
//  - Start: start pulse in cycle N while halted -> cycle N+1: running=1, w1=1, t1=1.
//    start pulses while running are ignored.
//  - Phase counter: T1 -> T2 -> T3 -> T1, one clock each, while running. A beat is 3 clocks.
//  - Beat transition is decided on the T3 clock from short/long/stop sampled in that clock.
//    The controller holds these stable for the whole beat.
//      stop=1 (any beat, highest priority): after T3, running=0, all outputs 0.
//      W1: short=1 -> next W1; else -> W2. long is ignored in W1.
//      W2: long=1 -> W3; else -> W1. short is ignored in W2.
//      W3: -> W1 always.
//  - stop and a start pulse in the same clock: stop wins. Restart needs a new qd release+press.
//  - Invariants: exactly one of t1..t3 and one of w1..w3 high iff running; never both beats
//    or phases high simultaneously.
//  - No wrap hazards. Phase and beat state are 2-bit encodings; illegal encodings recover
//    to halted on the next clock.
// STRUCTURE
//  - cpu_pkg: typedef enum logic[1:0] beat_t {B_IDLE,B_W1,B_W2,B_W3}.
//    typedef enum logic[1:0] phase_t {P_T1,P_T2,P_T3}.
//    localparam PHASES_PER_BEAT=3.
//  - Sub-module qd_debounce: sync + debounce + rising-edge pulse (params DEBOUNCE_CYCLES).
//  - timing_gen: beat FSM + phase counter + registered one-hot decode.
//    Outputs are registered, so they are glitch-free for the controller.
// TESTING
//  1 Reset: clr=1 for 2 clks with qd=1 -> all outputs 0, running=0; clr=0 with qd held
//    -> no start until qd released >=4 clks and re-pressed.
//  2 Start/plain cycle: qd pressed 10 clks, short=long=stop=0 -> w1 for 3 clks (t1,t2,t3),
//    w2 3 clks, then w1; start 1 clk after debounced edge (sync 2 + debounce 4).
//  3 Long: long=1 during W2 -> sequence W1,W2,W3,W1. Each beat is exactly 3 clks;
//    long=1 during W1 changes nothing.
//  4 Short: short=1 during W1 -> W1,W1,W1... with no w2 ever asserted; deassert -> W2 follows.
//  5 Stop: stop=1 in W2 T3 -> next clk all 0, running=0. Then a qd glitch of 2 clks
//    gives no restart; a clean 6-clk press restarts at W1/T1.
//  6 Mid-beat reset: clr=1 at W3 T2 -> next clk all 0. Simultaneous stop+start pulse -> stays halted.

Source files
------------

// File: rtl/timing_gen_pkg.sv
// Shared beat/phase encodings and beat-sequencing rule for the timing generator.
package cpu_pkg;

  typedef enum logic [1:0] {B_IDLE, B_W1, B_W2, B_W3} beat_t;
  typedef enum logic [1:0] {P_T1, P_T2, P_T3} phase_t;

  localparam int PHASES_PER_BEAT = 3;

  // Beat that follows a completed beat when no stop is requested.
  function automatic beat_t beat_after(beat_t b, logic is_short, logic is_long);
    case (b)
      B_W1:    return is_short ? B_W1 : B_W2;
      B_W2:    return is_long ? B_W3 : B_W1;
      default: return B_W1;
    endcase
  endfunction

endpackage

// File: rtl/timing_gen_if.sv
// Controller-facing bundle: start button and beat requests in, phase/beat levels out.
interface timing_gen_if;
  logic i_qd;
  logic i_short;
  logic i_long;
  logic i_stop;
  logic o_t1;
  logic o_t2;
  logic o_t3;
  logic o_w1;
  logic o_w2;
  logic o_w3;
  logic o_running;

  modport master (
    output i_qd, i_short, i_long, i_stop,
    input  o_t1, o_t2, o_t3, o_w1, o_w2, o_w3, o_running
  );

  modport slave (
    input  i_qd, i_short, i_long, i_stop,
    output o_t1, o_t2, o_t3, o_w1, o_w2, o_w3, o_running
  );
endinterface

// File: rtl/timing_gen_qd_debounce.sv
// Start button conditioning: 2-flop synchroniser, counting debouncer and a
// one-clock pulse on each rising edge of the debounced level.
module qd_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic i_qd,
  output logic o_start
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  // The level resets high so a button still held through clr cannot start the
  // machine; it must be seen released before a press counts.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_qd;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_start = r_level & ~r_level_d;

endmodule

// File: rtl/timing_gen.sv
// Beat/phase timing generator: beat FSM plus phase counter with registered
// one-hot outputs so the downstream controller sees glitch-free levels.
module timing_gen
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic          clk,
  input logic          clr,
  timing_gen_if.slave  bus
);

  logic   w_start;
  beat_t  r_beat;
  beat_t  w_beat_next;
  phase_t r_phase;
  phase_t w_phase_next;
  logic   r_t1, r_t2, r_t3;
  logic   r_w1, r_w2, r_w3;
  logic   r_running;

  qd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_qd_debounce (
    .clk     (clk),
    .clr     (clr),
    .i_qd    (bus.i_qd),
    .o_start (w_start)
  );

  // Start pulses are only looked at while idle; an illegal phase halts.
  always_comb begin
    w_beat_next  = r_beat;
    w_phase_next = P_T1;
    if (r_beat == B_IDLE) begin
      if (w_start) w_beat_next = B_W1;
    end else begin
      case (r_phase)
        P_T1:    w_phase_next = P_T2;
        P_T2:    w_phase_next = P_T3;
        P_T3:    w_beat_next  = bus.i_stop ? B_IDLE
                                           : beat_after(r_beat, bus.i_short, bus.i_long);
        default: w_beat_next  = B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_beat    <= B_IDLE;
      r_phase   <= P_T1;
      r_running <= 1'b0;
      r_t1      <= 1'b0;
      r_t2      <= 1'b0;
      r_t3      <= 1'b0;
      r_w1      <= 1'b0;
      r_w2      <= 1'b0;
      r_w3      <= 1'b0;
    end else begin
      r_beat    <= w_beat_next;
      r_phase   <= w_phase_next;
      r_running <= (w_beat_next != B_IDLE);
      r_t1      <= (w_beat_next != B_IDLE) && (w_phase_next == P_T1);
      r_t2      <= (w_beat_next != B_IDLE) && (w_phase_next == P_T2);
      r_t3      <= (w_beat_next != B_IDLE) && (w_phase_next == P_T3);
      r_w1      <= (w_beat_next == B_W1);
      r_w2      <= (w_beat_next == B_W2);
      r_w3      <= (w_beat_next == B_W3);
    end
  end

  assign bus.o_t1      = r_t1;
  assign bus.o_t2      = r_t2;
  assign bus.o_t3      = r_t3;
  assign bus.o_w1      = r_w1;
  assign bus.o_w2      = r_w2;
  assign bus.o_w3      = r_w3;
  assign bus.o_running = r_running;

endmodule

// File: tb/tb_timing_gen.sv
// Self-checking bench for timing_gen: a cycle model feeds a scoreboard queue,
// plus directed checks on start latency, short/long/stop and mid-beat clear.
module tb_timing_gen;
  import cpu_pkg::*;

  localparam int DEB = 4;
  localparam logic [6:0] V_W1T1 = 7'b1001001;
  localparam logic [6:0] V_W2T1 = 7'b1010001;
  localparam logic [6:0] V_W2T3 = 7'b1010100;
  localparam logic [6:0] V_W3T2 = 7'b1100010;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  timing_gen_if u_if ();

  timing_gen #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk (clk),
    .clr (clr),
    .bus (u_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;
  logic [6:0] exp_q[$];

  // Reference model state
  int m_s1, m_s2, m_lvl, m_lvld, m_cnt, m_run, m_beat, m_ph;

  function automatic logic [6:0] obs();
    return {u_if.o_running, u_if.o_w3, u_if.o_w2, u_if.o_w1,
            u_if.o_t3, u_if.o_t2, u_if.o_t1};
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, n_cyc, got, exp);
    end
  endtask

  task automatic tick();
    int         start;
    logic [6:0] e;
    logic [2:0] wv;
    logic [2:0] tv;
    start = (m_lvl == 1 && m_lvld == 0) ? 1 : 0;
    if (clr) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 1; m_lvld = 1; m_cnt = 0;
      m_run = 0; m_beat = 1; m_ph = 0;
    end else begin
      if (m_run == 0) begin
        if (start == 1) begin
          m_run = 1; m_beat = 1; m_ph = 0;
        end
      end else if (m_ph < PHASES_PER_BEAT - 1) begin
        m_ph++;
      end else begin
        m_ph = 0;
        if (u_if.i_stop)       m_run = 0;
        else if (m_beat == 1)  m_beat = u_if.i_short ? 1 : 2;
        else if (m_beat == 2)  m_beat = u_if.i_long ? 3 : 1;
        else                   m_beat = 1;
      end
      m_lvld = m_lvl;
      if (m_s2 != m_lvl) begin
        if (m_cnt == DEB - 1) begin
          m_lvl = m_s2; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
      end
      m_s2 = m_s1;
      m_s1 = int'(u_if.i_qd);
    end
    wv = 3'(1 << (m_beat - 1));
    tv = 3'(1 << m_ph);
    e  = (m_run != 0) ? {1'b1, wv, tv} : 7'd0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_cyc++;
    check_val("cycle", int'(obs()), int'(exp_q.pop_front()));
  endtask

  initial begin
    int lat;
    int seen;
    logic [6:0] first;

    u_if.i_qd = 1'b1; u_if.i_short = 1'b0; u_if.i_long = 1'b0; u_if.i_stop = 1'b0;
    clr = 1'b1;

    // 1: reset with button held, then no start until release and re-press
    tick(); tick();
    check_val("rst_outputs", int'(obs()), 0);
    clr = 1'b0;
    repeat (12) tick();
    check_val("held_qd_no_start", int'(u_if.o_running), 0);
    u_if.i_qd = 1'b0;
    repeat (8) tick();

    // 2: 10-clock press, plain W1/W2 sequence
    u_if.i_qd = 1'b1; lat = 0; first = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (lat == 0 && u_if.o_running) begin lat = i; first = obs(); end
      if (i == 10) u_if.i_qd = 1'b0;
    end
    check_val("start_latency", lat, 7);
    check_val("start_w1t1", int'(first), int'(V_W1T1));

    // 3: long requests W3 after W2
    u_if.i_long = 1'b1; seen = 0;
    repeat (18) begin tick(); if (u_if.o_w3) seen++; end
    check_val("long_w3_seen", int'(seen > 0), 1);
    u_if.i_long = 1'b0;

    // 4: short keeps repeating W1
    for (int i = 0; i < 9 && obs() != V_W1T1; i++) tick();
    check_val("align_w1t1", int'(obs()), int'(V_W1T1));
    u_if.i_short = 1'b1; seen = 0;
    repeat (15) begin tick(); if (u_if.o_w2) seen++; end
    check_val("short_no_w2", seen, 0);
    u_if.i_short = 1'b0; seen = 0;
    repeat (6) begin tick(); if (u_if.o_w2) seen++; end
    check_val("short_release_w2", int'(seen > 0), 1);

    // 5: stop in W2, glitch ignored, clean press restarts
    for (int i = 0; i < 12 && obs() != V_W2T1; i++) tick();
    check_val("align_w2t1", int'(obs()), int'(V_W2T1));
    u_if.i_stop = 1'b1;
    tick(); tick();
    check_val("stop_w2t3", int'(obs()), int'(V_W2T3));
    tick();
    check_val("stop_halt", int'(obs()), 0);
    u_if.i_stop = 1'b0;
    u_if.i_qd = 1'b1; tick(); tick(); u_if.i_qd = 1'b0;
    repeat (10) tick();
    check_val("glitch_no_start", int'(u_if.o_running), 0);
    u_if.i_qd = 1'b1; lat = 0; first = '0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 6) u_if.i_qd = 1'b0;
      if (lat == 0 && u_if.o_running) begin lat = i; first = obs(); end
    end
    check_val("restart_latency", lat, 7);
    check_val("restart_w1t1", int'(first), int'(V_W1T1));

    // 6: clr in W3 T2 aborts the beat
    u_if.i_long = 1'b1;
    for (int i = 0; i < 15 && obs() != V_W3T2; i++) tick();
    check_val("align_w3t2", int'(obs()), int'(V_W3T2));
    clr = 1'b1;
    tick();
    check_val("clr_abort", int'(obs()), 0);
    clr = 1'b0; u_if.i_long = 1'b0;
    repeat (10) tick();
    check_val("after_clr_idle", int'(u_if.o_running), 0);

    // 6b: stop and start pulse in the same clock -> stays halted
    u_if.i_qd = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 8) u_if.i_qd = 1'b0;
    end
    check_val("rerun", int'(u_if.o_running), 1);
    repeat (10) tick();
    for (int i = 0; i < 4 && !u_if.o_t3; i++) tick();
    check_val("align_t3", int'(u_if.o_t3), 1);
    u_if.i_qd = 1'b1;
    repeat (4) tick();
    u_if.i_stop = 1'b1;
    tick(); tick();
    check_val("coinc_t3", int'(u_if.o_t3), 1);
    tick();
    check_val("coinc_halt", int'(u_if.o_running), 0);
    repeat (8) tick();
    check_val("coinc_stays_halted", int'(obs()), 0);
    u_if.i_stop = 1'b0; u_if.i_qd = 1'b0;
    repeat (4) tick();

    check_val("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
